// File: rtl/key_press_encoder.sv
// key_press_encoder: synchronizes and debounces the four active-low push
// buttons, turns each accepted press into a single event and holds that event
// in a one-entry valid/ready buffer for the game FSM.
module key_press_encoder #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic       CLOCK_50,
  input  logic       RST_N,
  input  logic [3:0] KEY,
  input  logic       press_ready,
  input  logic       overflow_clr,
  output logic       press_valid,
  output logic [1:0] press_idx,
  output logic [3:0] press_onehot_n,
  output logic [3:0] held,
  output logic       multi_press,
  output logic       overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_t;

  // Lowest set bit wins when several keys are accepted together.
  function automatic logic [1:0] lowest_idx(input logic [3:0] v);
    logic [1:0] idx;
    if (v[0]) begin
      idx = 2'd0;
    end else if (v[1]) begin
      idx = 2'd1;
    end else if (v[2]) begin
      idx = 2'd2;
    end else begin
      idx = 2'd3;
    end
    return idx;
  endfunction

  // True when two or more bits of v are set.
  function automatic logic several_set(input logic [3:0] v);
    return (v & (v - 4'd1)) != 4'd0;
  endfunction

  logic [3:0]       sync1_r;
  logic [3:0]       sync2_r;
  logic [3:0]       db_r;
  logic [CNT_W-1:0] cnt_r [4];
  logic [3:0]       fall_s;
  logic             any_fall_s;
  logic [1:0]       win_idx_s;
  buf_state_t       state_r;
  buf_state_t       state_next_s;
  logic [1:0]       idx_r;
  logic [1:0]       idx_next_s;
  logic             drop_s;
  logic             overflow_r;

  // Two-flop synchronizer; released (1) is the safe reset level.
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      sync1_r <= 4'b1111;
      sync2_r <= 4'b1111;
    end else begin
      sync1_r <= KEY;
      sync2_r <= sync1_r;
    end
  end

  // Per-key debounce: a new level must persist DEBOUNCE_CYCLES cycles.
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      db_r <= 4'b1111;
      for (int i = 0; i < 4; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2_r[i] == db_r[i]) begin
          cnt_r[i] <= CNT_ZERO;
        end else if (cnt_r[i] == CNT_MAX) begin
          db_r[i]  <= sync2_r[i];
          cnt_r[i] <= CNT_ZERO;
        end else begin
          cnt_r[i] <= cnt_r[i] + CNT_ONE;
        end
      end
    end
  end

  // Press detection: debounced level about to be accepted 1 -> 0.
  always_comb begin
    fall_s = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      fall_s[i] = db_r[i] & ~sync2_r[i] & (cnt_r[i] == CNT_MAX);
    end
  end

  assign any_fall_s  = |fall_s;
  assign win_idx_s   = lowest_idx(fall_s);
  assign multi_press = several_set(fall_s);

  // Event buffer state and index registers.
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      state_r <= BUF_EMPTY;
      idx_r   <= 2'd0;
    end else begin
      state_r <= state_next_s;
      idx_r   <= idx_next_s;
    end
  end

  // Buffer next state: load, hand over back-to-back, or drop when full.
  always_comb begin
    state_next_s = state_r;
    idx_next_s   = idx_r;
    drop_s       = 1'b0;
    case (state_r)
      BUF_EMPTY: begin
        if (any_fall_s) begin
          state_next_s = BUF_FULL;
          idx_next_s   = win_idx_s;
        end else begin
          state_next_s = BUF_EMPTY;
        end
      end
      BUF_FULL: begin
        if (press_ready) begin
          if (any_fall_s) begin
            state_next_s = BUF_FULL;
            idx_next_s   = win_idx_s;
          end else begin
            state_next_s = BUF_EMPTY;
          end
        end else if (any_fall_s) begin
          drop_s = 1'b1;
        end else begin
          state_next_s = BUF_FULL;
        end
      end
      default: begin
        state_next_s = BUF_EMPTY;
        idx_next_s   = 2'd0;
      end
    endcase
  end

  // Sticky overflow; a drop in the clearing cycle keeps it set.
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end else if (overflow_clr) begin
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  assign press_valid    = (state_r == BUF_FULL);
  assign press_idx      = idx_r;
  assign press_onehot_n = press_valid ? ~(4'b0001 << idx_r) : 4'b1111;
  assign held           = ~db_r;
  assign overflow       = overflow_r;

endmodule

// File: tb/tb_key_press_encoder.sv
// Directed bench for key_press_encoder with a sample-window reference model.
module tb_key_press_encoder;
  localparam int D = 4;

  logic       CLOCK_50;
  logic       RST_N;
  logic [3:0] KEY;
  logic       press_ready;
  logic       overflow_clr;
  logic       press_valid;
  logic [1:0] press_idx;
  logic [3:0] press_onehot_n;
  logic [3:0] held;
  logic       multi_press;
  logic       overflow;

  int n_vec  = 0;
  int n_miss = 0;

  key_press_encoder #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .CLOCK_50(CLOCK_50), .RST_N(RST_N), .KEY(KEY),
    .press_ready(press_ready), .overflow_clr(overflow_clr),
    .press_valid(press_valid), .press_idx(press_idx),
    .press_onehot_n(press_onehot_n), .held(held),
    .multi_press(multi_press), .overflow(overflow)
  );

  initial begin
    CLOCK_50 = 1'b0;
    forever #10 CLOCK_50 = ~CLOCK_50;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: raw key samples, newest first; a level is accepted
  // when the D samples before the newest one all show the other level.
  logic [3:0] hist [D+1];
  logic [3:0] m_db;
  logic       m_valid;
  logic [1:0] m_idx;
  logic       m_ovf;

  always @(negedge CLOCK_50) begin
    logic [3:0] acc;
    logic [3:0] f;
    logic       m_multi;
    logic [1:0] win;
    if (!RST_N) begin
      for (int k = 0; k <= D; k++) hist[k] = 4'b1111;
      m_db = 4'b1111; m_valid = 1'b0; m_idx = 2'd0; m_ovf = 1'b0;
    end
    acc = 4'b0000;
    if (RST_N) begin
      for (int i = 0; i < 4; i++) begin
        logic same;
        same = 1'b1;
        for (int k = 1; k <= D; k++) if (hist[k][i] != hist[1][i]) same = 1'b0;
        if (same && hist[1][i] != m_db[i]) acc[i] = 1'b1;
      end
    end
    f = acc & m_db;
    m_multi = ($countones(f) >= 2);
    chk("valid", {7'd0, press_valid}, {7'd0, m_valid});
    if (m_valid) chk("idx", {6'd0, press_idx}, {6'd0, m_idx});
    chk("onehot_n", {4'd0, press_onehot_n}, {4'd0, m_valid ? ~(4'b0001 << m_idx) : 4'b1111});
    chk("held", {4'd0, held}, {4'd0, ~m_db});
    chk("multi", {7'd0, multi_press}, {7'd0, m_multi});
    chk("overflow", {7'd0, overflow}, {7'd0, m_ovf});
    if (RST_N) begin
      win = 2'd0;
      for (int i = 3; i >= 0; i--) if (f[i]) win = 2'(i);
      if (m_valid && press_ready) m_valid = 1'b0;
      if (f != 4'b0000) begin
        if (!m_valid) begin
          m_valid = 1'b1; m_idx = win;
        end else begin
          m_ovf = 1'b1;
        end
      end else if (overflow_clr) begin
        m_ovf = 1'b0;
      end
      m_db = m_db ^ acc;
      for (int k = D; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = KEY;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLOCK_50);
    #2;
  endtask

  initial begin
    int evts;
    logic [1:0] eidx;
    RST_N = 1'b0; KEY = 4'b1111; press_ready = 1'b0; overflow_clr = 1'b0;
    tick(2);
    chk("rst_valid", {7'd0, press_valid}, 8'd0);
    chk("rst_onehot", {4'd0, press_onehot_n}, 8'h0f);
    RST_N = 1'b1;
    tick(2);

    // 1: KEY[2] pressed, event after edge 5, one handshake clears it
    KEY = 4'b1011;
    tick(5);
    chk("t1_early", {7'd0, press_valid}, 8'd0);
    tick(1);
    chk("t1_valid", {7'd0, press_valid}, 8'd1);
    chk("t1_idx", {6'd0, press_idx}, 8'd2);
    chk("t1_onehot", {4'd0, press_onehot_n}, 8'h0b);
    chk("t1_held", {4'd0, held}, 8'h04);
    press_ready = 1'b1; tick(1); press_ready = 1'b0;
    chk("t1_consumed", {7'd0, press_valid}, 8'd0);
    KEY = 4'b1111; tick(8);
    chk("t1_released", {4'd0, held}, 8'h00);

    // 2: KEY[1] bounces, then stays low: exactly one event
    press_ready = 1'b1; evts = 0; eidx = 2'd0;
    for (int i = 0; i < 20; i++) begin
      KEY = (i == 3) ? 4'b1111 : 4'b1101;
      tick(1);
      if (press_valid && press_ready) begin evts++; eidx = press_idx; end
    end
    chk("t2_events", 8'(evts), 8'd1);
    chk("t2_idx", {6'd0, eidx}, 8'd1);
    press_ready = 1'b0; KEY = 4'b1111; tick(8);

    // 3: KEY[0] and KEY[3] together: key 0 wins, multi_press one cycle
    KEY = 4'b0110;
    tick(5);
    chk("t3_multi_hi", {7'd0, multi_press}, 8'd1);
    tick(1);
    chk("t3_multi_lo", {7'd0, multi_press}, 8'd0);
    chk("t3_idx", {6'd0, press_idx}, 8'd0);
    chk("t3_held", {4'd0, held}, 8'h09);
    press_ready = 1'b1; tick(1); press_ready = 1'b0;
    tick(3);
    chk("t3_no_key3", {7'd0, press_valid}, 8'd0);
    KEY = 4'b1111; tick(8);

    // 4: second press while full is dropped, overflow sticky until cleared
    KEY = 4'b1101; tick(6);
    KEY = 4'b1001; tick(6);
    chk("t4_kept", {6'd0, press_idx}, 8'd1);
    chk("t4_ovf", {7'd0, overflow}, 8'd1);
    overflow_clr = 1'b1; tick(1); overflow_clr = 1'b0;
    chk("t4_clr", {7'd0, overflow}, 8'd0);
    press_ready = 1'b1; tick(1); press_ready = 1'b0;
    KEY = 4'b1111; tick(8);

    // 5: handshake and new fall on the same edge: no bubble, no overflow
    KEY = 4'b1110; tick(6);
    KEY = 4'b0110; tick(5);
    press_ready = 1'b1; tick(1); press_ready = 1'b0;
    chk("t5_valid", {7'd0, press_valid}, 8'd1);
    chk("t5_idx", {6'd0, press_idx}, 8'd3);
    chk("t5_ovf", {7'd0, overflow}, 8'd0);
    press_ready = 1'b1; tick(1); press_ready = 1'b0;
    KEY = 4'b1111; tick(8);

    // 6: reset mid-count with KEY[2] held: one event after release
    KEY = 4'b1011; tick(3);
    RST_N = 1'b0; tick(1);
    chk("t6_rst_held", {4'd0, held}, 8'h00);
    chk("t6_rst_valid", {7'd0, press_valid}, 8'd0);
    tick(1);
    RST_N = 1'b1;
    tick(5);
    chk("t6_early", {7'd0, press_valid}, 8'd0);
    tick(1);
    chk("t6_valid", {7'd0, press_valid}, 8'd1);
    chk("t6_idx", {6'd0, press_idx}, 8'd2);
    press_ready = 1'b1; tick(1); press_ready = 1'b0;
    tick(10);
    chk("t6_single", {7'd0, press_valid}, 8'd0);
    KEY = 4'b1111; tick(8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
